// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock ratio monitor.
//   mon_state_e  : monitor FSM encoding
//   err_flags_t  : sticky error flag bundle
//   SYNC_STAGES  : synchronizer depth ahead of the edge detector
//   WARMUP_CYCLES: cycles after reset release before clock_1x toggle checking is armed
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic ratio_err;
        logic stall_err;
        logic toggle_err;
    } err_flags_t;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned WARMUP_CYCLES = 3;
    localparam int unsigned MATCH_W       = 4;
    localparam int unsigned WARM_W        = $clog2(WARMUP_CYCLES + 1);

endpackage

// File: rtl/clk_ratio_monitor_if.sv
// Signal bundle between the clock generator side and the ratio monitor.
//   clock_1x_in, clock_slower_in : generated clocks, sampled as data by the monitor
//   err_clear                    : one-cycle pulse clearing the sticky error flags
//   locked, *_err, last_half_period : monitor status
// master = generator / stimulus side, slave = monitor.
interface clk_ratio_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             clock_1x_in;
    logic             clock_slower_in;
    logic             err_clear;
    logic             locked;
    logic             ratio_err;
    logic             stall_err;
    logic             toggle_err;
    logic [CNT_W-1:0] last_half_period;

    modport master (
        output clock_1x_in, clock_slower_in, err_clear,
        input  locked, ratio_err, stall_err, toggle_err, last_half_period
    );

    modport slave (
        input  clock_1x_in, clock_slower_in, err_clear,
        output locked, ratio_err, stall_err, toggle_err, last_half_period
    );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by a previous-value flop; flags any change
// of the synchronized level.
//   clk, rst_n : monitor clock, async active-low reset
//   d          : asynchronous level input
//   edge_c     : high for one cycle per level change (combinational from flops)
module sync_edge_det
    import clk_mon_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_c = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures the clock_slower half-period in original_clock cycles, declares lock
// after LOCK_COUNT consecutive half-periods equal to RATIO, and raises sticky
// errors on ratio mismatch while locked, on stall, and on clock_1x not toggling.
//   original_clock : monitor clock
//   reset_in       : async active-low reset
//   mon            : slave side of clk_ratio_monitor_if (sampled clocks, err_clear,
//                    locked, ratio_err, stall_err, toggle_err, last_half_period)
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned RATIO       = 5,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned STALL_LIMIT = 20,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                original_clock,
    input  logic                reset_in,
    clk_ratio_monitor_if.slave  mon
);

    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   RATIO_C    = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0]   STALL_LAST = CNT_W'(STALL_LIMIT - 1);
    localparam logic [MATCH_W-1:0] LOCK_C     = MATCH_W'(LOCK_COUNT);
    localparam logic [WARM_W-1:0]  WARM_DONE  = WARM_W'(WARMUP_CYCLES);

    logic fast_edge_c;
    logic slow_edge_c;

    mon_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   lhp_q, lhp_d;
    logic [CNT_W-1:0]   measured_c;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MATCH_W-1:0] match_inc_c;
    logic [WARM_W-1:0]  warm_q, warm_d;
    logic               locked_q, locked_d;
    err_flags_t         err_q, err_d, err_set_c;

    sync_edge_det u_sync_1x (
        .clk    (original_clock),
        .rst_n  (reset_in),
        .d      (mon.clock_1x_in),
        .edge_c (fast_edge_c)
    );

    sync_edge_det u_sync_slower (
        .clk    (original_clock),
        .rst_n  (reset_in),
        .d      (mon.clock_slower_in),
        .edge_c (slow_edge_c)
    );

    // State and status registers
    always_ff @(posedge original_clock or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= ACQUIRE;
            cnt_q    <= '0;
            lhp_q    <= '0;
            match_q  <= '0;
            warm_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lhp_q    <= lhp_d;
            match_q  <= match_d;
            warm_q   <= warm_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    // Next-state: measurement, lock tracking, stall and sticky flags
    always_comb begin
        state_d     = state_q;
        lhp_d       = lhp_q;
        match_d     = match_q;
        err_set_c   = '0;
        cnt_d       = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        measured_c  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        match_inc_c = match_q + MATCH_W'(1);
        warm_d      = (warm_q == WARM_DONE) ? warm_q : warm_q + WARM_W'(1);

        if (slow_edge_c) begin
            // An edge always restarts the count, even if the stall limit is hit now
            cnt_d = '0;
            case (state_q)
                ACQUIRE: begin
                    state_d = TRACK;
                    match_d = '0;
                end
                TRACK: begin
                    lhp_d = measured_c;
                    if (measured_c == RATIO_C) begin
                        match_d = match_inc_c;
                        if (match_inc_c == LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    lhp_d = measured_c;
                    if (measured_c != RATIO_C) begin
                        err_set_c.ratio_err = 1'b1;
                        state_d             = TRACK;
                        match_d             = '0;
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    match_d = '0;
                end
            endcase
        end else if (cnt_q >= STALL_LAST) begin
            // Incremented count would reach STALL_LIMIT: flag it this cycle
            err_set_c.stall_err = 1'b1;
            state_d             = ACQUIRE;
            match_d             = '0;
            cnt_d               = '0;
        end

        err_set_c.toggle_err = (warm_q == WARM_DONE) && !fast_edge_c;

        // Set beats clear when both happen in the same cycle
        err_d    = err_set_c | (err_q & ~{3{mon.err_clear}});
        locked_d = (state_d == LOCKED);
    end

    assign mon.locked           = locked_q;
    assign mon.ratio_err        = err_q.ratio_err;
    assign mon.stall_err        = err_q.stall_err;
    assign mon.toggle_err       = err_q.toggle_err;
    assign mon.last_half_period = lhp_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor (RATIO=5, LOCK_COUNT=4, STALL_LIMIT=20).
// clock_1x_in toggles on every falling edge of original_clock; clock_slower_in
// toggles at chosen falling edges so each half-period is an exact cycle count.
// Outputs are sampled on falling edges; an input toggle is reflected in the
// outputs three falling edges later.
module tb_clk_ratio_monitor;

    localparam int unsigned CNT_W = 8;

    logic original_clock = 1'b0;
    logic reset_in;

    clk_ratio_monitor_if #(.CNT_W(CNT_W)) mon_if ();

    clk_ratio_monitor #(
        .RATIO       (5),
        .LOCK_COUNT  (4),
        .STALL_LIMIT (20),
        .CNT_W       (CNT_W)
    ) dut (
        .original_clock (original_clock),
        .reset_in       (reset_in),
        .mon            (mon_if)
    );

    always #5 original_clock = ~original_clock;

    typedef struct {
        int               n;
        logic             locked;
        logic             ratio_err;
        logic [CNT_W-1:0] lhp;
    } vec_t;

    vec_t tbl[18];
    int   errors = 0;
    int   checks = 0;
    int   since  = 0;
    bit   tx_en  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic re, input logic se,
                           input logic te, input logic [CNT_W-1:0] lhp);
        chk({tag, ".locked"},     32'(mon_if.locked),           32'(lk));
        chk({tag, ".ratio_err"},  32'(mon_if.ratio_err),        32'(re));
        chk({tag, ".stall_err"},  32'(mon_if.stall_err),        32'(se));
        chk({tag, ".toggle_err"}, 32'(mon_if.toggle_err),       32'(te));
        chk({tag, ".lhp"},        32'(mon_if.last_half_period), 32'(lhp));
    endtask

    // Advance to the next falling edge, keeping clock_1x toggling unless held
    task automatic wait_neg();
        @(negedge original_clock);
        since++;
        if (tx_en) mon_if.clock_1x_in = ~mon_if.clock_1x_in;
    endtask

    // Toggle clock_slower n cycles after its previous toggle, then step to where
    // the resulting edge is visible at the outputs
    task automatic apply(input int n);
        while (since < n) wait_neg();
        mon_if.clock_slower_in = ~mon_if.clock_slower_in;
        since = 0;
        repeat (3) wait_neg();
    endtask

    task automatic run_rows(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            apply(tbl[i].n);
            chk_all($sformatf("%s[%0d]", tag, i), tbl[i].locked, tbl[i].ratio_err, 1'b0, 1'b0,
                    tbl[i].lhp);
        end
    endtask

    task automatic pulse_clear();
        mon_if.err_clear = 1'b1;
        wait_neg();
        mon_if.err_clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            n  lock rerr lhp
        tbl[0]  = '{3, 1'b0, 1'b0, 8'd0};   // ACQUIRE edge, no measurement
        tbl[1]  = '{5, 1'b0, 1'b0, 8'd5};
        tbl[2]  = '{5, 1'b0, 1'b0, 8'd5};
        tbl[3]  = '{5, 1'b0, 1'b0, 8'd5};
        tbl[4]  = '{5, 1'b1, 1'b0, 8'd5};   // 4th match -> lock
        tbl[5]  = '{5, 1'b1, 1'b0, 8'd5};
        tbl[6]  = '{7, 1'b0, 1'b1, 8'd7};   // stretched half-period while locked
        tbl[7]  = '{5, 1'b0, 1'b1, 8'd5};
        tbl[8]  = '{5, 1'b0, 1'b1, 8'd5};
        tbl[9]  = '{5, 1'b0, 1'b1, 8'd5};
        tbl[10] = '{5, 1'b1, 1'b1, 8'd5};   // relock
        tbl[11] = '{3, 1'b0, 1'b1, 8'd3};   // short half-period while locked
        tbl[12] = '{5, 1'b0, 1'b1, 8'd5};
        tbl[13] = '{6, 1'b0, 1'b1, 8'd6};   // mismatch in TRACK restarts count
        tbl[14] = '{5, 1'b0, 1'b1, 8'd5};
        tbl[15] = '{5, 1'b0, 1'b1, 8'd5};
        tbl[16] = '{5, 1'b0, 1'b1, 8'd5};
        tbl[17] = '{5, 1'b1, 1'b1, 8'd5};

        reset_in               = 1'b0;
        mon_if.clock_1x_in     = 1'b0;
        mon_if.clock_slower_in = 1'b0;
        mon_if.err_clear       = 1'b0;
        repeat (3) wait_neg();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        reset_in = 1'b1;
        since    = 0;

        // Lock acquisition, ratio glitches, relock
        run_rows(0, 17, "tbl");

        pulse_clear();
        chk("clear.ratio_err", 32'(mon_if.ratio_err), 32'd0);

        // Nominal operation for 1000 cycles
        for (int i = 0; i < 200; i++) begin
            apply(5);
            chk_all($sformatf("nom[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        end

        // Stall: freeze clock_slower; flag exactly 20 cycles after the last edge
        while (since < 22) wait_neg();
        chk_all("stall.pre", 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        wait_neg();
        chk_all("stall.fire", 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);

        while (since < 25) wait_neg();
        pulse_clear();
        chk("stall.clear", 32'(mon_if.stall_err), 32'd0);

        // Clear in the same cycle as the next stall: set wins
        while (since < 42) wait_neg();
        chk("collide.pre", 32'(mon_if.stall_err), 32'd0);
        pulse_clear();
        chk("collide.stall_err", 32'(mon_if.stall_err), 32'd1);

        // clock_1x holds its level for two cycles
        tx_en = 1'b0;
        wait_neg();
        tx_en = 1'b1;
        wait_neg();
        wait_neg();
        chk("toggle.pre", 32'(mon_if.toggle_err), 32'd0);
        wait_neg();
        chk("toggle.fire", 32'(mon_if.toggle_err), 32'd1);
        pulse_clear();
        chk("toggle.clear", 32'(mon_if.toggle_err), 32'd0);
        chk("toggle.clear_stall", 32'(mon_if.stall_err), 32'd0);

        // After a stall the monitor is back in ACQUIRE: five edges to relock
        apply(3);
        chk_all("reacq[0]", 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        for (int i = 1; i <= 4; i++) begin
            apply(5);
            chk_all($sformatf("reacq[%0d]", i), (i == 4), 1'b0, 1'b0, 1'b0, 8'd5);
        end

        // Async reset between clock edges while locked
        @(posedge original_clock);
        #2 reset_in = 1'b0;
        #1 chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        mon_if.clock_slower_in = 1'b0;
        repeat (3) wait_neg();
        chk_all("async_rst.hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        reset_in = 1'b1;
        since    = 0;
        run_rows(0, 5, "relock");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
